window_buffer: RTL and testbench

WINDOW_BUFFER -- requirements
Module: window_buffer

---
 rtl/window_buffer.sv | 114 +++++++++++
 tb/tb_window_buffer.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/window_buffer.sv
// 3x3 sliding-window generator over a raster pixel stream, backed by two line buffers.
// Define WINBUF_FRAME_CNT_EN to add the frame_cnt output and its counter.
module window_buffer #(
   parameter int IMG_W = 8,
   parameter int IMG_H = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  in_pix,
   input  logic        in_valid,
   input  logic        in_sof,
   output logic        in_ready,
   output logic [23:0] cache_out [0:2],
   output logic        out_valid,
   input  logic        out_ready,
   output logic        frame_done
`ifdef WINBUF_FRAME_CNT_EN
   ,
   output logic [15:0] frame_cnt
`endif
);

   localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
   localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

   logic [CW-1:0] r_col;
   logic [RW-1:0] r_row;
   logic [7:0]    r_lb1 [0:IMG_W-1];
   logic [7:0]    r_lb2 [0:IMG_W-1];
   logic [23:0]   r_win_p1 [0:2];
   logic          r_vld_p1;
   logic          r_done_p1;

   logic          w_accept;
   logic [CW-1:0] w_col;
   logic [RW-1:0] w_row;
   logic          w_win;
   logic          w_last;
   logic [7:0]    w_up1;
   logic [7:0]    w_up2;

   assign in_ready = !r_vld_p1 || out_ready;
   assign w_accept = in_valid && in_ready;

   // An accepted sof pixel is always position (0,0), whatever the counters say.
   assign w_col  = in_sof ? '0 : r_col;
   assign w_row  = in_sof ? '0 : r_row;
   assign w_win  = (w_row >= RW'(2)) && (w_col >= CW'(2));
   // frame_done looks at the raw counters so an sof on the last pixel still closes the frame.
   assign w_last = (r_row == ROW_LAST) && (r_col == COL_LAST);
   assign w_up1  = r_lb1[w_col];
   assign w_up2  = r_lb2[w_col];

   // Line buffers: r_lb1 holds row r-1, r_lb2 row r-2; stale contents are gated by row >= 2.
   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_lb2[w_col] <= w_up1;
         r_lb1[w_col] <= in_pix;
      end
   end

   // ---- stage p1: window shift register, position counters, output handshake ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_col       <= '0;
         r_row       <= '0;
         r_vld_p1    <= 1'b0;
         r_done_p1   <= 1'b0;
         r_win_p1[0] <= '0;
         r_win_p1[1] <= '0;
         r_win_p1[2] <= '0;
      end else begin
         r_done_p1 <= w_accept && w_last;
         if (w_accept) begin
            r_win_p1[0] <= {r_win_p1[0][15:0], w_up2};
            r_win_p1[1] <= {r_win_p1[1][15:0], w_up1};
            r_win_p1[2] <= {r_win_p1[2][15:0], in_pix};
            r_vld_p1    <= w_win;
            if (w_col == COL_LAST) begin
               r_col <= '0;
               r_row <= (w_row == ROW_LAST) ? '0 : w_row + 1'b1;
            end else begin
               r_col <= w_col + 1'b1;
               r_row <= w_row;
            end
         end else if (out_ready) begin
            r_vld_p1 <= 1'b0;
         end
      end
   end

   assign cache_out[0] = r_win_p1[0];
   assign cache_out[1] = r_win_p1[1];
   assign cache_out[2] = r_win_p1[2];
   assign out_valid    = r_vld_p1;
   assign frame_done   = r_done_p1;

`ifdef WINBUF_FRAME_CNT_EN
   logic [15:0] r_frame_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_frame_cnt <= '0;
      end else if (w_accept && w_last) begin
         r_frame_cnt <= r_frame_cnt + 16'd1;
      end
   end

   assign frame_cnt = r_frame_cnt;
`endif

endmodule

// File: tb/tb_window_buffer.sv
// Self-checking bench for window_buffer (4x4 image): frame-memory model feeding a window
// scoreboard, a table of whole-frame vectors, and hand-written corner-case sequences.
module tb_window_buffer;

   localparam int W = 4;
   localparam int H = 4;

   logic        clk;
   logic        rst_n;
   logic [7:0]  in_pix;
   logic        in_valid;
   logic        in_sof;
   logic        in_ready;
   logic [23:0] cache_out [0:2];
   logic        out_valid;
   logic        out_ready;
   logic        frame_done;
`ifdef WINBUF_FRAME_CNT_EN
   logic [15:0] frame_cnt;
`endif

   window_buffer #(.IMG_W(W), .IMG_H(H)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_pix     (in_pix),
      .in_valid   (in_valid),
      .in_sof     (in_sof),
      .in_ready   (in_ready),
      .cache_out  (cache_out),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .frame_done (frame_done)
`ifdef WINBUF_FRAME_CNT_EN
      ,
      .frame_cnt  (frame_cnt)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int          checks = 0;
   int          errors = 0;
   int          done_cnt = 0;
   int          exp_done = 0;
   int          mrow = 0;
   int          mcol = 0;
   int          rx_count = 0;
   logic [71:0] rx_first = '0;
   logic [71:0] rx_last = '0;
   logic [7:0]  img [H][W];
   logic [71:0] sb [$];
   bit          busy;

   typedef struct {
      int          mode;
      logic [7:0]  val;
      int          exp_win;
      logic [23:0] first0;
      logic [23:0] first2;
      logic [23:0] last2;
   } fvec_t;

   fvec_t vecs [4];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h required %0h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] pat(input int mode, input logic [7:0] val, input int r, input int c);
      case (mode)
         0:       return val;
         1:       return 8'(int'(val) + r * 16 + c);
         2:       return 8'(int'(val) - (r * 16 + c));
         default: return 8'($urandom_range(0, 255));
      endcase
   endfunction

   // Reference: whole-frame memory; a window is read straight from the stored image.
   task automatic model_accept(input logic [7:0] p, input logic sof);
      if (mrow == H - 1 && mcol == W - 1) exp_done++;
      if (sof) begin
         mrow = 0;
         mcol = 0;
      end
      img[mrow][mcol] = p;
      if (mrow >= 2 && mcol >= 2)
         sb.push_back({img[mrow-2][mcol-2], img[mrow-2][mcol-1], img[mrow-2][mcol],
                       img[mrow-1][mcol-2], img[mrow-1][mcol-1], img[mrow-1][mcol],
                       img[mrow][mcol-2],   img[mrow][mcol-1],   img[mrow][mcol]});
      if (mcol == W - 1) begin
         mcol = 0;
         mrow = (mrow == H - 1) ? 0 : mrow + 1;
      end else begin
         mcol++;
      end
   endtask

   task automatic drive_pix(input logic [7:0] p, input logic sof);
      int n;
      in_pix   = p;
      in_sof   = sof;
      in_valid = 1'b1;
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 200) begin
         n++;
         @(negedge clk);
      end
      if (!in_ready) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout: in_ready=0 after %0d cycles, required 1", n);
      end else begin
         model_accept(p, sof);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_sof   = 1'b0;
   endtask

   task automatic send_frame(input int mode, input logic [7:0] val, input logic sof_first);
      for (int r = 0; r < H; r++)
         for (int c = 0; c < W; c++)
            drive_pix(pat(mode, val, r, c), sof_first && r == 0 && c == 0);
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      logic [71:0] got;
      logic [71:0] exp;
      if (rst_n && out_valid && out_ready) begin
         got = {cache_out[0], cache_out[1], cache_out[2]};
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL window_unexpected: got %018h required no window", got);
         end else begin
            exp = sb.pop_front();
            if (got !== exp) begin
               errors++;
               $display("FAIL window: got %018h required %018h", got, exp);
            end
         end
         if (rx_count == 0) rx_first = got;
         rx_last = got;
         rx_count++;
      end
      if (frame_done) done_cnt++;
   end

   initial begin
      int d0;
      in_pix    = '0;
      in_valid  = 1'b0;
      in_sof    = 1'b0;
      out_ready = 1'b1;
      rst_n     = 1'b1;

      vecs[0] = '{0, 8'd11, 4, 24'h0B0B0B, 24'h0B0B0B, 24'h0B0B0B};
      vecs[1] = '{1, 8'h00, 4, 24'h000102, 24'h202122, 24'h313233};
      vecs[2] = '{0, 8'hFF, 4, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF};
      vecs[3] = '{2, 8'hFF, 4, 24'hFFFEFD, 24'hDFDEDD, 24'hCECDCC};

      #3 rst_n = 1'b0;
      #2;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_frame_done", 32'(frame_done), 32'd0);
      chk("rst_cache0", 32'(cache_out[0]), 32'd0);
      chk("rst_cache2", 32'(cache_out[2]), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1 rst_n = 1'b1;
      idle(1);

      // Whole-frame vectors, back to back.
      for (int i = 0; i < 4; i++) begin
         d0 = done_cnt;
         rx_count = 0;
         send_frame(vecs[i].mode, vecs[i].val, 1'b1);
         idle(2);
         chk($sformatf("vec%0d_windows", i), 32'(rx_count), 32'(vecs[i].exp_win));
         chk($sformatf("vec%0d_first_row0", i), 32'(rx_first[71:48]), 32'(vecs[i].first0));
         chk($sformatf("vec%0d_first_row2", i), 32'(rx_first[23:0]), 32'(vecs[i].first2));
         chk($sformatf("vec%0d_last_row2", i), 32'(rx_last[23:0]), 32'(vecs[i].last2));
         chk($sformatf("vec%0d_frame_done", i), 32'(done_cnt - d0), 32'd1);
      end

      // Backpressure: stall on the first window of a ramp frame.
      rx_count  = 0;
      out_ready = 1'b0;
      for (int k = 0; k <= 10; k++)
         drive_pix(pat(1, 8'h00, k / W, k % W), k == 0);
      fork
         begin
            for (int k = 11; k < W * H; k++)
               drive_pix(pat(1, 8'h00, k / W, k % W), 1'b0);
         end
         begin
            for (int t = 0; t < 3; t++) begin
               @(negedge clk);
               chk("bp_out_valid", 32'(out_valid), 32'd1);
               chk("bp_in_ready", 32'(in_ready), 32'd0);
               chk("bp_cache_row0", 32'(cache_out[0]), 32'h000102);
               chk("bp_cache_row2", 32'(cache_out[2]), 32'h202122);
            end
            @(posedge clk);
            #1 out_ready = 1'b1;
         end
      join
      idle(2);
      chk("bp_windows", 32'(rx_count), 32'd4);
      chk("bp_last_row2", 32'(rx_last[23:0]), 32'h313233);

      // sof arriving at row 2 / col 1 of a running frame.
      rx_count = 0;
      for (int k = 0; k <= 8; k++)
         drive_pix(pat(1, 8'h00, k / W, k % W), k == 0);
      for (int k = 0; k < W * H; k++) begin
         if (k == 10) begin
            chk("sof_no_window", 32'(rx_count), 32'd0);
            chk("sof_out_valid", 32'(out_valid), 32'd0);
         end
         drive_pix(pat(1, 8'h80, k / W, k % W), k == 0);
      end
      idle(2);
      chk("sof_windows", 32'(rx_count), 32'd4);
      chk("sof_first_row0", 32'(rx_first[71:48]), 32'h808182);
      chk("sof_last_row2", 32'(rx_last[23:0]), 32'hB1B2B3);

      // Reset pulse at row 3 while a window is pending.
      for (int k = 0; k <= 14; k++)
         drive_pix(pat(1, 8'h00, k / W, k % W), k == 0);
      chk("prerst_out_valid", 32'(out_valid), 32'd1);
      #1 rst_n = 1'b0;
      #1;
      chk("midrst_out_valid", 32'(out_valid), 32'd0);
      chk("midrst_cache1", 32'(cache_out[1]), 32'd0);
      sb.delete();
      mrow = 0;
      mcol = 0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      rx_count = 0;
      send_frame(1, 8'h40, 1'b0);
      idle(2);
      chk("postrst_windows", 32'(rx_count), 32'd4);
      chk("postrst_first_row0", 32'(rx_first[71:48]), 32'h404142);
      chk("postrst_last_row2", 32'(rx_last[23:0]), 32'h717273);

      // sof on the last pixel of a frame: frame closes and a new one starts.
      rx_count = 0;
      d0 = done_cnt;
      for (int k = 0; k < W * H - 1; k++)
         drive_pix(pat(1, 8'h10, k / W, k % W), k == 0);
      drive_pix(8'h55, 1'b1);
      idle(1);
      chk("lastsof_frame_done", 32'(done_cnt - d0), 32'd1);
      for (int k = 1; k < W * H; k++)
         drive_pix(pat(1, 8'h60, k / W, k % W), 1'b0);
      idle(2);
      chk("lastsof_windows", 32'(rx_count), 32'd7);
      chk("lastsof_done_total", 32'(done_cnt - d0), 32'd2);
      chk("lastsof_last_row0", 32'(rx_last[71:48]), 32'h717273);

      // Random pixels with random downstream stalls.
      rx_count = 0;
      busy = 1'b1;
      fork
         begin
            send_frame(3, 8'h00, 1'b1);
            busy = 1'b0;
         end
         begin
            while (busy) begin
               @(posedge clk);
               #1 out_ready = ($urandom_range(0, 1) == 1);
            end
         end
      join
      out_ready = 1'b1;
      idle(3);
      chk("rand_windows", 32'(rx_count), 32'd4);

      chk("sb_empty", 32'(sb.size()), 32'd0);
      chk("frame_done_total", 32'(done_cnt), 32'(exp_done));
`ifdef WINBUF_FRAME_CNT_EN
      chk("frame_cnt", 32'(frame_cnt), 32'(exp_done));
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
